// File: rtl/dma_engine_pkg.sv
// Shared definitions for the SSRAM bus DMA engine.
//   dma_state_e : engine FSM states
//   SEL_*       : cfgSel register codes
//   CTRL_*_BIT  : control register start bits
//   STAT_*_BIT  : status register bit positions
package dma_engine_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_BEGIN = 3'd2,
    ST_RDATA = 3'd3,
    ST_WDATA = 3'd4,
    ST_WEND  = 3'd5,
    ST_DONE  = 3'd6
  } dma_state_e;

  localparam logic [2:0] SEL_BUS_ADDR   = 3'd0;
  localparam logic [2:0] SEL_MEM_ADDR   = 3'd1;
  localparam logic [2:0] SEL_BLOCK_SIZE = 3'd2;
  localparam logic [2:0] SEL_BURST_SIZE = 3'd3;
  localparam logic [2:0] SEL_CONTROL    = 3'd4;
  localparam logic [2:0] SEL_STATUS     = 3'd5;

  localparam int CTRL_RD_BIT   = 0;  // bus -> SSRAM
  localparam int CTRL_WR_BIT   = 1;  // SSRAM -> bus
  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_ERR_BIT  = 1;
  localparam int STAT_DONE_BIT = 2;

endpackage

// File: rtl/dma_write_prefetch.sv
// Two-entry skid buffer between SSRAM port-B read data (1-cycle latency)
// and the bus write beats.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   flush_i        discard all held words
//   in_valid_i     SSRAM read data valid this cycle (read issued last cycle)
//   in_data_i      SSRAM read data
//   out_en_i       engine is in the write-data phase
//   out_ready_i    bus accepts the beat (busyIn low)
//   out_valid_o    beat valid, out_data_o beat data
//   pop_o          beat accepted this cycle
//   count_o        words held in the buffer
// Handshake: a beat transfers on a cycle where out_valid_o && out_ready_i;
// out_data_o stays stable while out_valid_o is high and out_ready_i is low.
// When the buffer is empty, incoming SSRAM data bypasses straight to the bus.
module dma_write_prefetch (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        in_valid_i,
  input  logic [31:0] in_data_i,
  input  logic        out_en_i,
  input  logic        out_ready_i,
  output logic        out_valid_o,
  output logic [31:0] out_data_o,
  output logic        pop_o,
  output logic [1:0]  count_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] e0_q, e0_d, e1_q, e1_d;
  logic [31:0] w0, w1;

  always_comb begin
    out_valid_o = out_en_i && ((cnt_q != 2'd0) || in_valid_i);
    out_data_o  = (cnt_q != 2'd0) ? e0_q : in_data_i;
    pop_o       = out_valid_o && out_ready_i;
    // Append the incoming word behind the held ones, then drop the head on pop.
    w0   = (cnt_q == 2'd0) ? in_data_i : e0_q;
    w1   = (cnt_q == 2'd1) ? in_data_i : e1_q;
    e0_d = pop_o ? w1 : w0;
    e1_d = pop_o ? in_data_i : w1;
    cnt_d = cnt_q + {1'b0, in_valid_i} - {1'b0, pop_o};
    if (flush_i) cnt_d = 2'd0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 2'd0;
      e0_q  <= '0;
      e1_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      e0_q  <= e0_d;
      e1_q  <= e1_d;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/ssram_bus_dma_engine.sv
// Bus-master DMA engine moving word blocks between the system bus and port B
// of the dual-port SSRAM, one transfer at a time, in bursts.
// Config via cfgWe/cfgSel/cfgData (0 busAddr, 1 memAddr, 2 blockSize,
// 3 burstSize, 4 control, 5 status W1C); cfgReadData returns the selected one.
// Bus master side: busRequest/busGranted, beginTransOut, addressDataOut,
// readNotWriteOut, burstSizeOut, byteEnablesOut, dataValidOut, endTransOut;
// slave side inputs busyIn, dataValidIn, dataIn, endTransIn, errorIn.
// SSRAM port B: memAddrB, memWeB, memDataOutB, memDataInB (1-cycle read).
// irqOut: completion interrupt, only when built with DMA_IRQ_EN defined.
// debugStateOut: current FSM state (dma_state_e encoding).
module ssram_bus_dma_engine
  import dma_engine_pkg::*;
#(
  parameter int MEM_ADDR_W = 9,
  parameter int BLOCK_W    = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cfgWe,
  input  logic [2:0]            cfgSel,
  input  logic [31:0]           cfgData,
  output logic [31:0]           cfgReadData,
  output logic                  busRequest,
  input  logic                  busGranted,
  output logic                  beginTransOut,
  output logic [31:0]           addressDataOut,
  output logic                  readNotWriteOut,
  output logic [7:0]            burstSizeOut,
  output logic [3:0]            byteEnablesOut,
  output logic                  dataValidOut,
  output logic                  endTransOut,
  input  logic                  busyIn,
  input  logic                  dataValidIn,
  input  logic [31:0]           dataIn,
  input  logic                  endTransIn,
  input  logic                  errorIn,
  output logic [MEM_ADDR_W-1:0] memAddrB,
  output logic                  memWeB,
  output logic [31:0]           memDataOutB,
  input  logic [31:0]           memDataInB,
  output logic                  irqOut,
  output logic [2:0]            debugStateOut
);

  dma_state_e            state_q, state_d;
  logic                  dir_q, dir_d;          // 1 = SSRAM -> bus
  logic [31:0]           busAddr_q, busAddr_d;
  logic [MEM_ADDR_W-1:0] memAddr_q, memAddr_d;
  logic [BLOCK_W-1:0]    blockSize_q, blockSize_d;
  logic [7:0]            burstSize_q, burstSize_d;
  logic [BLOCK_W-1:0]    rem_q, rem_d;          // words not yet given a burst
  logic [BLOCK_W-1:0]    beats_q, beats_d;      // length of current burst
  logic [BLOCK_W-1:0]    beatCnt_q, beatCnt_d;
  logic [BLOCK_W-1:0]    fetchLeft_q, fetchLeft_d;
  logic                  pend_q;                // SSRAM read in flight
  logic                  error_q, error_d, done_q, done_d;

  logic                  busy, busActive, issue;
  logic [BLOCK_W-1:0]    burstLen, len;
  logic                  pfValid, pfPop;
  logic [31:0]           pfData;
  logic [1:0]            pfCount, fillNext;

  assign busy      = (state_q != ST_IDLE);
  assign busActive = (state_q == ST_REQ) || (state_q == ST_BEGIN) ||
                     (state_q == ST_RDATA) || (state_q == ST_WDATA) ||
                     (state_q == ST_WEND);
  assign burstLen  = BLOCK_W'({1'b0, burstSize_q}) + BLOCK_W'(1);
  assign len       = (rem_q < burstLen) ? rem_q : burstLen;
  // Buffer occupancy after this cycle; a new read may only be issued if its
  // data will still find a free slot when it lands next cycle.
  assign fillNext  = pfCount + {1'b0, pend_q} - {1'b0, pfPop};

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    busAddr_d   = busAddr_q;
    memAddr_d   = memAddr_q;
    blockSize_d = blockSize_q;
    burstSize_d = burstSize_q;
    rem_d       = rem_q;
    beats_d     = beats_q;
    beatCnt_d   = beatCnt_q;
    fetchLeft_d = fetchLeft_q;
    error_d     = error_q;
    done_d      = done_q;
    issue       = 1'b0;

    if (cfgWe && (cfgSel == SEL_STATUS)) begin
      if (cfgData[STAT_ERR_BIT])  error_d = 1'b0;
      if (cfgData[STAT_DONE_BIT]) done_d  = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (cfgWe) begin
          case (cfgSel)
            SEL_BUS_ADDR:   busAddr_d   = {cfgData[31:2], 2'b00};
            SEL_MEM_ADDR:   memAddr_d   = cfgData[MEM_ADDR_W-1:0];
            SEL_BLOCK_SIZE: blockSize_d = cfgData[BLOCK_W-1:0];
            SEL_BURST_SIZE: burstSize_d = cfgData[7:0];
            SEL_CONTROL: begin
              if ((cfgData[CTRL_RD_BIT] ^ cfgData[CTRL_WR_BIT]) &&
                  (blockSize_q != '0)) begin
                state_d = ST_REQ;
                dir_d   = cfgData[CTRL_WR_BIT];
                rem_d   = blockSize_q;
              end
            end
            default: ;
          endcase
        end
      end
      ST_REQ: if (busGranted) state_d = ST_BEGIN;
      ST_BEGIN: begin
        beats_d   = len;
        beatCnt_d = '0;
        rem_d     = rem_q - len;
        busAddr_d = busAddr_q + (32'(len) << 2);
        if (dir_q) begin
          // First SSRAM read goes out now so data is there for the first beat.
          issue       = 1'b1;
          fetchLeft_d = len - BLOCK_W'(1);
          memAddr_d   = memAddr_q + MEM_ADDR_W'(1);
          state_d     = ST_WDATA;
        end else begin
          state_d = ST_RDATA;
        end
      end
      ST_RDATA: begin
        if (dataValidIn) memAddr_d = memAddr_q + MEM_ADDR_W'(1);
        if (endTransIn) state_d = (rem_q == '0) ? ST_DONE : ST_REQ;
      end
      ST_WDATA: begin
        if ((fetchLeft_q != '0) && (fillNext <= 2'd1)) begin
          issue       = 1'b1;
          fetchLeft_d = fetchLeft_q - BLOCK_W'(1);
          memAddr_d   = memAddr_q + MEM_ADDR_W'(1);
        end
        if (pfPop) begin
          beatCnt_d = beatCnt_q + BLOCK_W'(1);
          if (beatCnt_q == beats_q - BLOCK_W'(1)) state_d = ST_WEND;
        end
      end
      ST_WEND: state_d = (rem_q == '0) ? ST_DONE : ST_REQ;
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A bus error abandons the rest of the block.
    if (errorIn && busActive) begin
      state_d = ST_IDLE;
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      dir_q       <= 1'b0;
      busAddr_q   <= '0;
      memAddr_q   <= '0;
      blockSize_q <= '0;
      burstSize_q <= '0;
      rem_q       <= '0;
      beats_q     <= '0;
      beatCnt_q   <= '0;
      fetchLeft_q <= '0;
      pend_q      <= 1'b0;
      error_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      busAddr_q   <= busAddr_d;
      memAddr_q   <= memAddr_d;
      blockSize_q <= blockSize_d;
      burstSize_q <= burstSize_d;
      rem_q       <= rem_d;
      beats_q     <= beats_d;
      beatCnt_q   <= beatCnt_d;
      fetchLeft_q <= fetchLeft_d;
      pend_q      <= issue;
      error_q     <= error_d;
      done_q      <= done_d;
    end
  end

  dma_write_prefetch u_prefetch (
    .clk_i       (clock),
    .rst_i       (reset),
    .flush_i     (state_q == ST_IDLE),
    .in_valid_i  (pend_q),
    .in_data_i   (memDataInB),
    .out_en_i    (state_q == ST_WDATA),
    .out_ready_i (!busyIn),
    .out_valid_o (pfValid),
    .out_data_o  (pfData),
    .pop_o       (pfPop),
    .count_o     (pfCount)
  );

  assign busRequest      = busActive;
  assign beginTransOut   = (state_q == ST_BEGIN);
  assign readNotWriteOut = beginTransOut && !dir_q;
  assign burstSizeOut    = beginTransOut ? 8'(len - BLOCK_W'(1)) : 8'h00;
  assign byteEnablesOut  = beginTransOut ? 4'hF : 4'h0;
  assign dataValidOut    = pfValid;
  assign addressDataOut  = beginTransOut ? busAddr_q : (pfValid ? pfData : 32'h0);
  assign endTransOut     = (state_q == ST_WEND);
  assign memWeB          = (state_q == ST_RDATA) && dataValidIn && !errorIn;
  assign memDataOutB     = memWeB ? dataIn : 32'h0;
  assign memAddrB        = (memWeB || issue) ? memAddr_q : '0;
  assign debugStateOut   = state_q;

  always_comb begin
    cfgReadData = 32'h0;
    case (cfgSel)
      SEL_BUS_ADDR:   cfgReadData = busAddr_q;
      SEL_MEM_ADDR:   cfgReadData = 32'(memAddr_q);
      SEL_BLOCK_SIZE: cfgReadData = 32'(blockSize_q);
      SEL_BURST_SIZE: cfgReadData = {24'h0, burstSize_q};
      SEL_CONTROL:    cfgReadData = {30'h0, busy && dir_q, busy && !dir_q};
      SEL_STATUS:     cfgReadData = {29'h0, done_q, error_q, busy};
      default:        cfgReadData = 32'h0;
    endcase
  end

`ifdef DMA_IRQ_EN
  assign irqOut = done_q | error_q;
`else
  assign irqOut = 1'b0;
`endif

endmodule

// File: tb/tb_ssram_bus_dma_engine.sv
module tb_ssram_bus_dma_engine;

`ifdef DMA_IRQ_EN
  localparam logic IRQ_EN = 1'b1;
`else
  localparam logic IRQ_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cfgWe = 1'b0;
  logic [2:0]  cfgSel = 3'd5;
  logic [31:0] cfgData = 32'h0;
  logic [31:0] cfgReadData;
  logic        busRequest, beginTransOut, readNotWriteOut, dataValidOut, endTransOut;
  logic        busGranted = 1'b0;
  logic [31:0] addressDataOut;
  logic [7:0]  burstSizeOut;
  logic [3:0]  byteEnablesOut;
  logic        busyIn = 1'b0, dataValidIn = 1'b0, endTransIn = 1'b0, errorIn = 1'b0;
  logic [31:0] dataIn = 32'h0;
  logic [8:0]  memAddrB;
  logic        memWeB;
  logic [31:0] memDataOutB;
  logic [31:0] memDataInB;
  logic        irqOut;
  logic [2:0]  debugStateOut;

  logic [31:0] sram [512];
  logic [31:0] exp_q [$];
  int n_checks = 0;
  int n_fails  = 0;

  ssram_bus_dma_engine dut (
    .clock(clock), .reset(reset), .cfgWe(cfgWe), .cfgSel(cfgSel), .cfgData(cfgData),
    .cfgReadData(cfgReadData), .busRequest(busRequest), .busGranted(busGranted),
    .beginTransOut(beginTransOut), .addressDataOut(addressDataOut),
    .readNotWriteOut(readNotWriteOut), .burstSizeOut(burstSizeOut),
    .byteEnablesOut(byteEnablesOut), .dataValidOut(dataValidOut),
    .endTransOut(endTransOut), .busyIn(busyIn), .dataValidIn(dataValidIn),
    .dataIn(dataIn), .endTransIn(endTransIn), .errorIn(errorIn),
    .memAddrB(memAddrB), .memWeB(memWeB), .memDataOutB(memDataOutB),
    .memDataInB(memDataInB), .irqOut(irqOut), .debugStateOut(debugStateOut)
  );

  // clock / SSRAM port-B model (1-cycle read latency, preloaded during reset)
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 512; i++) sram[i] <= 32'h5A00_0000 | i;
      memDataInB <= 32'h0;
    end else begin
      if (memWeB) sram[memAddrB] <= memDataOutB;
      memDataInB <= sram[memAddrB];
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic cfg_write(input logic [2:0] sel, input logic [31:0] data);
    cfgWe = 1'b1; cfgSel = sel; cfgData = data;
    tick();
    cfgWe = 1'b0; cfgSel = 3'd5; cfgData = 32'h0;
  endtask

  task automatic configure(input logic [31:0] ba, input logic [31:0] ma,
                           input logic [31:0] blk, input logic [31:0] bst);
    cfg_write(3'd0, ba); cfg_write(3'd1, ma); cfg_write(3'd2, blk); cfg_write(3'd3, bst);
  endtask

  task automatic wait_begin(input logic [31:0] ea, input logic [7:0] eb, input logic ernw);
    int n = 0;
    while (!(busRequest === 1'b1 && endTransOut === 1'b0) && n < 50) begin tick(); n++; end
    n_checks++;
    if (busRequest !== 1'b1) begin n_fails++; $display("FAIL req: busRequest=%b want 1", busRequest); end
    busGranted = 1'b1;
    tick();
    busGranted = 1'b0;
    n_checks++;
    if (beginTransOut !== 1'b1) begin n_fails++; $display("FAIL begin: beginTransOut=%b want 1", beginTransOut); end
    n_checks++;
    if (addressDataOut !== ea) begin n_fails++; $display("FAIL begin_addr: got %h want %h", addressDataOut, ea); end
    n_checks++;
    if (burstSizeOut !== eb) begin n_fails++; $display("FAIL burst_size: got %0d want %0d", burstSizeOut, eb); end
    n_checks++;
    if (readNotWriteOut !== ernw) begin n_fails++; $display("FAIL rnw: got %b want %b", readNotWriteOut, ernw); end
    n_checks++;
    if (byteEnablesOut !== 4'hF) begin n_fails++; $display("FAIL byte_en: got %h want f", byteEnablesOut); end
  endtask

  task automatic read_burst(input logic [31:0] ea, input logic [7:0] eb, input logic [8:0] mbase,
                            input int nbeats, input logic [31:0] seed);
    logic [8:0] ema;
    wait_begin(ea, eb, 1'b1);
    tick();
    for (int i = 0; i < nbeats; i++) begin
      dataValidIn = 1'b1; dataIn = seed + i; endTransIn = (i == nbeats - 1);
      ema = mbase + 9'(i);
      exp_q.push_back(seed + i);
      #1;
      n_checks++;
      if (memWeB !== 1'b1 || memAddrB !== ema) begin
        n_fails++; $display("FAIL rd_mem_addr: we=%b addr=%h want we=1 addr=%h", memWeB, memAddrB, ema);
      end
      n_checks++;
      if (memDataOutB !== seed + i) begin n_fails++; $display("FAIL rd_mem_data: got %h want %h", memDataOutB, seed + i); end
      @(posedge clock); #1;
    end
    dataValidIn = 1'b0; endTransIn = 1'b0; dataIn = 32'h0;
  endtask

  task automatic write_burst(input logic [31:0] ea, input logic [7:0] eb, input int nbeats,
                             input int stall_beat, input int stall_len);
    int acc = 0, stalls = 0, cyc = 0;
    wait_begin(ea, eb, 1'b0);
    tick();
    while (acc < nbeats && cyc < 40) begin
      busyIn = (acc == stall_beat && stalls < stall_len);
      #1;
      if (dataValidOut === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fails++; $display("FAIL wr_extra_beat: got %h with no beat expected", addressDataOut);
        end else if (addressDataOut !== exp_q[0]) begin
          n_fails++; $display("FAIL wr_beat: got %h want %h (busy=%b)", addressDataOut, exp_q[0], busyIn);
        end
        if (busyIn) stalls++;
        else begin acc++; if (exp_q.size() != 0) void'(exp_q.pop_front()); end
      end
      @(posedge clock); #1;
      cyc++;
    end
    busyIn = 1'b0;
    n_checks++;
    if (acc != nbeats) begin n_fails++; $display("FAIL wr_beat_count: got %0d want %0d", acc, nbeats); end
    n_checks++;
    if (endTransOut !== 1'b1) begin n_fails++; $display("FAIL wr_end: endTransOut=%b want 1", endTransOut); end
    n_checks++;
    if (dataValidOut !== 1'b0) begin n_fails++; $display("FAIL wr_valid_after_end: got %b want 0", dataValidOut); end
  endtask

  task automatic wait_idle(input logic [31:0] est, input logic eirq);
    int n = 0;
    cfgSel = 3'd5;
    while (cfgReadData[0] !== 1'b0 && n < 20) begin tick(); n++; end
    n_checks++;
    if (cfgReadData !== est) begin n_fails++; $display("FAIL status: got %h want %h", cfgReadData, est); end
    n_checks++;
    if (irqOut !== eirq) begin n_fails++; $display("FAIL irq: got %b want %b", irqOut, eirq); end
  endtask

  // scoreboard: drain expected words against SSRAM contents
  task automatic check_mem(input logic [8:0] base, input int n);
    logic [31:0] e;
    for (int i = 0; i < n; i++) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
      n_checks++;
      if (sram[base + 9'(i)] !== e) begin
        n_fails++; $display("FAIL mem[%h]: got %h want %h", base + 9'(i), sram[base + 9'(i)], e);
      end
    end
  endtask

  task automatic clear_status();
    cfg_write(3'd5, 32'h6);
    n_checks++;
    if (cfgReadData !== 32'h0 || irqOut !== 1'b0) begin
      n_fails++; $display("FAIL status_clear: status=%h irq=%b want 0/0", cfgReadData, irqOut);
    end
  endtask

  // scenarios
  task automatic test_reset();
    reset = 1'b1; tick(); tick();
    reset = 1'b0; #1;
    for (int s = 0; s < 6; s++) begin
      cfgSel = 3'(s); #1;
      n_checks++;
      if (cfgReadData !== 32'h0) begin n_fails++; $display("FAIL reset_reg%0d: got %h want 0", s, cfgReadData); end
    end
    cfgSel = 3'd5;
    n_checks++;
    if ({busRequest, beginTransOut, dataValidOut, endTransOut, memWeB, irqOut} !== 6'b0 ||
        addressDataOut !== 32'h0 || memAddrB !== 9'h0 || burstSizeOut !== 8'h0) begin
      n_fails++; $display("FAIL reset_outputs: req=%b beg=%b addr=%h want all 0", busRequest, beginTransOut, addressDataOut);
    end
    n_checks++;
    if (debugStateOut !== 3'd0) begin n_fails++; $display("FAIL reset_state: got %0d want 0", debugStateOut); end
    tick();
  endtask

  task automatic test_read_two_bursts();
    configure(32'h1000, 32'h0, 32'd8, 32'd3);
    cfg_write(3'd4, 32'h1);
    read_burst(32'h1000, 8'd3, 9'h000, 4, 32'hA000_0000);
    read_burst(32'h1010, 8'd3, 9'h004, 4, 32'hA000_0004);
    wait_idle(32'h4, IRQ_EN);
    check_mem(9'h000, 8);
    clear_status();
  endtask

  task automatic test_write_split();
    configure(32'h2000, 32'h20, 32'd5, 32'd3);
    for (int i = 0; i < 5; i++) exp_q.push_back(32'h5A00_0020 + i);
    cfg_write(3'd4, 32'h2);
    write_burst(32'h2000, 8'd3, 4, -1, 0);
    write_burst(32'h2010, 8'd0, 1, -1, 0);
    wait_idle(32'h4, IRQ_EN);
    clear_status();
  endtask

  task automatic test_write_stall();
    configure(32'h3000, 32'h40, 32'd4, 32'd3);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h5A00_0040 + i);
    cfg_write(3'd4, 32'h2);
    write_burst(32'h3000, 8'd3, 4, 2, 3);
    wait_idle(32'h4, IRQ_EN);
    clear_status();
  endtask

  task automatic test_read_error();
    configure(32'h5000, 32'h80, 32'd8, 32'd3);
    cfg_write(3'd4, 32'h1);
    read_burst(32'h5000, 8'd3, 9'h080, 4, 32'hB000_0000);
    wait_begin(32'h5010, 8'd3, 1'b1);
    tick();
    dataValidIn = 1'b1; dataIn = 32'hB000_0004; exp_q.push_back(32'hB000_0004);
    tick();
    dataValidIn = 1'b0; errorIn = 1'b1;
    tick();
    errorIn = 1'b0;
    n_checks++;
    if (busRequest !== 1'b0) begin n_fails++; $display("FAIL err_release: busRequest=%b want 0", busRequest); end
    wait_idle(32'h2, IRQ_EN);
    exp_q.push_back(32'h5A00_0085);  // untouched word after the abort
    check_mem(9'h080, 6);
    clear_status();
  endtask

  task automatic test_mem_wrap();
    configure(32'h6003, 32'h1FE, 32'd4, 32'd3);  // low address bits must be dropped
    cfg_write(3'd4, 32'h1);
    read_burst(32'h6000, 8'd3, 9'h1FE, 4, 32'hC000_0000);
    wait_idle(32'h4, IRQ_EN);
    check_mem(9'h1FE, 2);
    check_mem(9'h000, 2);
    clear_status();
  endtask

  task automatic test_reset_and_ignores();
    configure(32'h7000, 32'h100, 32'd8, 32'd7);
    cfg_write(3'd4, 32'h1);
    wait_begin(32'h7000, 8'd7, 1'b1);
    tick();
    dataValidIn = 1'b1; dataIn = 32'hD0; tick(); tick();
    dataValidIn = 1'b0; reset = 1'b1;
    tick();
    n_checks++;
    if ({busRequest, beginTransOut, dataValidOut, endTransOut, memWeB} !== 5'b0 || cfgReadData !== 32'h0) begin
      n_fails++; $display("FAIL mid_reset: req=%b end=%b we=%b status=%h want 0", busRequest, endTransOut, memWeB, cfgReadData);
    end
    reset = 1'b0; tick();
    // writes while busy must not disturb the running transfer
    configure(32'h8000, 32'h10, 32'd2, 32'd0);
    cfg_write(3'd4, 32'h1);
    cfg_write(3'd0, 32'h9000);
    cfg_write(3'd4, 32'h2);
    read_burst(32'h8000, 8'd0, 9'h010, 1, 32'hE000_0000);
    read_burst(32'h8004, 8'd0, 9'h011, 1, 32'hE000_0001);
    wait_idle(32'h4, IRQ_EN);
    check_mem(9'h010, 2);
    clear_status();
    // zero-length block and double start bits do nothing
    cfg_write(3'd2, 32'd0);
    cfg_write(3'd4, 32'h1);
    tick();
    n_checks++;
    if (busRequest !== 1'b0 || cfgReadData !== 32'h0) begin
      n_fails++; $display("FAIL zero_block: req=%b status=%h want 0/0", busRequest, cfgReadData);
    end
    cfg_write(3'd2, 32'd4);
    cfg_write(3'd4, 32'h3);
    tick();
    n_checks++;
    if (busRequest !== 1'b0 || cfgReadData !== 32'h0) begin
      n_fails++; $display("FAIL both_start: req=%b status=%h want 0/0", busRequest, cfgReadData);
    end
  endtask

  initial begin
    test_reset();
    test_read_two_bursts();
    test_write_split();
    test_write_stall();
    test_read_error();
    test_mem_wrap();
    test_reset_and_ignores();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
